// File: rtl/password_lock_ctrl.sv
// password_lock_ctrl: keypad code entry, compare, failure lockout and code reprogramming
module password_lock_ctrl #(
  parameter int DIGITS = 3,
  parameter logic [4*DIGITS-1:0] INIT_CODE = 12'h999,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int SHOW_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rmx,
  input  logic       prog,
  input  logic [9:0] button,
  output logic [1:0] LED_out,
  output logic       busy,
  output logic [1:0] fail_cnt
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TMAX = LOCK_CYCLES > SHOW_CYCLES ? LOCK_CYCLES : SHOW_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [CW-1:0] DN = CW'(DIGITS);
  localparam logic [TW-1:0] TS = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] TL = TW'(LOCK_CYCLES - 1);
  localparam logic [1:0] MF = 2'(MAX_FAIL);
  typedef enum logic [2:0] {IDLE, ENTRY, PASS, FAIL, LOCKED, PROG} state_t;
  state_t state_q, state_d;
  logic [4*DIGITS-1:0] buf_q, buf_d, code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0] fail_q, fail_d, led_q, led_d;
  logic bad_q, bad_d;
  logic [3:0] idx;
  logic onehot, full, ok;
  always_comb begin
    idx = 4'd0;
    for (int i = 0; i < 10; i++) if (button[i]) idx = 4'(i);
    onehot = button != 10'd0 && (button & (button - 10'd1)) == 10'd0;
    full = cnt_q == DN;
    ok = full && !bad_q;
    state_d = state_q;
    buf_d = buf_q;
    cnt_d = cnt_q;
    bad_d = bad_q;
    code_d = code_q;
    tmr_d = tmr_q;
    fail_d = fail_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ENTRY;
        buf_d = '0;
        cnt_d = '0;
        bad_d = 1'b0;
      end
      ENTRY, PROG: if (rmx) begin
        tmr_d = TS;
        if (state_q == PROG) begin
          state_d = ok ? PASS : FAIL;
          code_d = ok ? buf_q : code_q;
        end else if (ok && buf_q == code_q) begin
          state_d = PASS;
          fail_d = 2'd0;
        end else begin
          fail_d = fail_q + 2'd1;
          state_d = fail_d == MF ? LOCKED : FAIL;
          tmr_d = fail_d == MF ? TL : TS;
        end
      end else if (start && state_q == ENTRY) begin
        buf_d = '0;
        cnt_d = '0;
        bad_d = 1'b0;
      end else if (button != 10'd0) begin
        bad_d = bad_q || full || !onehot;
        cnt_d = full ? cnt_q : cnt_q + 1'b1;
        buf_d = (!full && onehot) ? {buf_q[4*DIGITS-5:0], idx} : buf_q;
      end
      PASS: if (prog) begin
        state_d = PROG;
        buf_d = '0;
        cnt_d = '0;
        bad_d = 1'b0;
      end else begin
        state_d = tmr_q == '0 ? IDLE : PASS;
        tmr_d = tmr_q == '0 ? tmr_q : tmr_q - 1'b1;
      end
      FAIL, LOCKED: begin
        state_d = tmr_q == '0 ? IDLE : state_q;
        tmr_d = tmr_q == '0 ? tmr_q : tmr_q - 1'b1;
        fail_d = (state_q == LOCKED && tmr_q == '0) ? 2'd0 : fail_q;
      end
      default: state_d = IDLE;
    endcase
    led_d = state_d == PASS ? 2'b01 : state_d == FAIL ? 2'b10 : state_d == LOCKED ? 2'b11 : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q <= '0;
      cnt_q <= '0;
      bad_q <= 1'b0;
      code_q <= INIT_CODE;
      tmr_q <= '0;
      fail_q <= 2'd0;
      led_q <= 2'b00;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      bad_q <= bad_d;
      code_q <= code_d;
      tmr_q <= tmr_d;
      fail_q <= fail_d;
      led_q <= led_d;
    end
  end
  assign LED_out = led_q;
  assign busy = state_q != IDLE;
  assign fail_cnt = fail_q;
endmodule

// File: tb/tb_password_lock_ctrl.sv
// tb_password_lock_ctrl: directed scoreboard bench for password_lock_ctrl
module tb_password_lock_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic rmx = 1'b0;
  logic prog = 1'b0;
  logic [9:0] button = 10'd0;
  logic [1:0] LED_out;
  logic busy;
  logic [1:0] fail_cnt;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string tag;
    logic [1:0] led;
    logic [1:0] fc;
    logic bz;
  } exp_t;
  exp_t sb[$];
  password_lock_ctrl dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rmx(rmx),
    .prog(prog),
    .button(button),
    .LED_out(LED_out),
    .busy(busy),
    .fail_cnt(fail_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [9:0] oh(input int d);
    logic [9:0] one;
    one = 10'd1;
    return one << d;
  endfunction
  task automatic cyc(input logic s, input logic r, input logic p, input logic [9:0] b,
                     input logic [1:0] eled, input logic [1:0] efail, input logic ebusy, input string tag);
    exp_t e;
    start = s;
    rmx = r;
    prog = p;
    button = b;
    sb.push_back('{tag, eled, efail, ebusy});
    @(posedge clk);
    #1;
    start = 1'b0;
    rmx = 1'b0;
    prog = 1'b0;
    button = 10'd0;
    e = sb.pop_front();
    checks++;
    assert (LED_out === e.led) else begin
      errors++;
      $error("FAIL %s LED_out got %b exp %b", e.tag, LED_out, e.led);
    end
    checks++;
    assert (fail_cnt === e.fc) else begin
      errors++;
      $error("FAIL %s fail_cnt got %0d exp %0d", e.tag, fail_cnt, e.fc);
    end
    checks++;
    assert (busy === e.bz) else begin
      errors++;
      $error("FAIL %s busy got %b exp %b", e.tag, busy, e.bz);
    end
  endtask
  task automatic do_reset(input string tag);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 10'h3ff, 2'b00, 2'd0, 1'b0, tag);
    rst = 1'b0;
  endtask
  task automatic key(input int d, input logic [1:0] f);
    cyc(1'b0, 1'b0, 1'b0, oh(d), 2'b00, f, 1'b1, "key");
  endtask
  task automatic enter3(input int d0, input int d1, input int d2, input logic [1:0] f);
    cyc(1'b1, 1'b0, 1'b0, 10'd0, 2'b00, f, 1'b1, "start");
    key(d0, f);
    key(d1, f);
    key(d2, f);
  endtask
  task automatic submit(input logic s, input logic [1:0] led, input int n,
                        input logic [1:0] fd, input logic [1:0] fa, input string tag);
    cyc(s, 1'b1, 1'b0, oh(5), led, fd, 1'b1, tag);
    repeat (n - 1) cyc(1'b0, 1'b0, 1'b0, 10'd0, led, fd, 1'b1, tag);
    cyc(1'b0, 1'b0, 1'b0, 10'd0, 2'b00, fa, 1'b0, {tag, "_end"});
  endtask
  initial begin
    do_reset("reset");
    cyc(1'b0, 1'b1, 1'b0, oh(9), 2'b00, 2'd0, 1'b0, "idle_rmx_ignored");
    enter3(9, 9, 9, 2'd0);
    submit(1'b0, 2'b01, 4, 2'd0, 2'd0, "pass999");
    enter3(9, 9, 7, 2'd0);
    submit(1'b0, 2'b10, 4, 2'd1, 2'd1, "fail997");
    enter3(7, 9, 7, 2'd1);
    submit(1'b0, 2'b10, 4, 2'd2, 2'd2, "fail797");
    enter3(9, 9, 7, 2'd2);
    cyc(1'b0, 1'b1, 1'b0, 10'd0, 2'b11, 2'd3, 1'b1, "lock");
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 10'd0, 2'b11, 2'd3, 1'b1, "lock_hold");
    cyc(1'b1, 1'b0, 1'b1, oh(9), 2'b11, 2'd3, 1'b1, "lock_start_ignored");
    repeat (9) cyc(1'b0, 1'b0, 1'b0, 10'd0, 2'b11, 2'd3, 1'b1, "lock_hold");
    cyc(1'b0, 1'b0, 1'b0, 10'd0, 2'b00, 2'd0, 1'b0, "lock_end");
    enter3(9, 9, 9, 2'd0);
    submit(1'b0, 2'b01, 4, 2'd0, 2'd0, "pass_after_lock");
    cyc(1'b1, 1'b0, 1'b0, 10'd0, 2'b00, 2'd0, 1'b1, "start");
    cyc(1'b0, 1'b0, 1'b0, 10'b10_1000_0000, 2'b00, 2'd0, 1'b1, "multihot");
    key(9, 2'd0);
    key(9, 2'd0);
    submit(1'b0, 2'b10, 4, 2'd1, 2'd1, "fail_multihot");
    cyc(1'b1, 1'b0, 1'b0, 10'd0, 2'b00, 2'd1, 1'b1, "start");
    key(9, 2'd1);
    key(9, 2'd1);
    submit(1'b0, 2'b10, 4, 2'd2, 2'd2, "fail_two_digits");
    cyc(1'b1, 1'b0, 1'b0, 10'd0, 2'b00, 2'd2, 1'b1, "start");
    key(9, 2'd2);
    cyc(1'b0, 1'b0, 1'b0, 10'd0, 2'b00, 2'd2, 1'b1, "no_button");
    key(9, 2'd2);
    key(9, 2'd2);
    submit(1'b0, 2'b01, 4, 2'd0, 2'd0, "pass_with_gap");
    enter3(9, 9, 9, 2'd0);
    key(9, 2'd0);
    submit(1'b0, 2'b10, 4, 2'd1, 2'd1, "fail_four_digits");
    enter3(1, 9, 9, 2'd1);
    cyc(1'b1, 1'b0, 1'b0, 10'd0, 2'b00, 2'd1, 1'b1, "restart");
    key(9, 2'd1);
    key(9, 2'd1);
    key(9, 2'd1);
    submit(1'b1, 2'b01, 4, 2'd0, 2'd0, "start_rmx_same");
    enter3(9, 9, 9, 2'd0);
    cyc(1'b0, 1'b1, 1'b0, 10'd0, 2'b01, 2'd0, 1'b1, "pass_before_prog");
    cyc(1'b0, 1'b0, 1'b1, 10'd0, 2'b00, 2'd0, 1'b1, "enter_prog");
    key(1, 2'd0);
    key(2, 2'd0);
    key(3, 2'd0);
    submit(1'b0, 2'b01, 4, 2'd0, 2'd0, "prog_ok");
    enter3(9, 9, 9, 2'd0);
    submit(1'b0, 2'b10, 4, 2'd1, 2'd1, "old_code_fails");
    enter3(1, 2, 3, 2'd1);
    submit(1'b0, 2'b01, 4, 2'd0, 2'd0, "new_code_passes");
    enter3(1, 2, 3, 2'd0);
    cyc(1'b0, 1'b1, 1'b0, 10'd0, 2'b01, 2'd0, 1'b1, "pass_before_prog2");
    cyc(1'b0, 1'b0, 1'b0, 10'd0, 2'b01, 2'd0, 1'b1, "pass_hold");
    cyc(1'b0, 1'b0, 1'b1, 10'd0, 2'b00, 2'd0, 1'b1, "enter_prog2");
    key(4, 2'd0);
    key(5, 2'd0);
    submit(1'b0, 2'b10, 4, 2'd0, 2'd0, "prog_short_fails");
    enter3(1, 2, 3, 2'd0);
    submit(1'b0, 2'b01, 4, 2'd0, 2'd0, "code_kept");
    cyc(1'b1, 1'b0, 1'b0, 10'd0, 2'b00, 2'd0, 1'b1, "start");
    key(1, 2'd0);
    key(2, 2'd0);
    do_reset("rst_mid_entry");
    enter3(9, 9, 9, 2'd0);
    submit(1'b0, 2'b01, 4, 2'd0, 2'd0, "code_restored");
    enter3(7, 7, 7, 2'd0);
    submit(1'b0, 2'b10, 4, 2'd1, 2'd1, "fail_a");
    enter3(7, 7, 7, 2'd1);
    submit(1'b0, 2'b10, 4, 2'd2, 2'd2, "fail_b");
    enter3(7, 7, 7, 2'd2);
    cyc(1'b0, 1'b1, 1'b0, 10'd0, 2'b11, 2'd3, 1'b1, "lock2");
    cyc(1'b0, 1'b0, 1'b0, 10'd0, 2'b11, 2'd3, 1'b1, "lock2_hold");
    do_reset("rst_mid_lock");
    cyc(1'b0, 1'b0, 1'b0, 10'd0, 2'b00, 2'd0, 1'b0, "idle_after_rst");
    enter3(9, 9, 9, 2'd0);
    submit(1'b0, 2'b01, 4, 2'd0, 2'd0, "pass_after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
